// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: vertical FSM states, default 640x480 vertical
// constants and sync polarity, reused by the horizontal and vertical stages.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        VS_ACTIVE      = 2'd0,
        VS_FRONT_PORCH = 2'd1,
        VS_SYNC        = 2'd2,
        VS_BACK_PORCH  = 2'd3
    } v_state_t;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // 0 = sync pulses are active-low (standard 640x480@60)
    localparam bit SYNC_POL_DEF = 1'b0;

    function automatic v_state_t next_v_state(input v_state_t s);
        v_state_t n;
        n = VS_ACTIVE;
        case (s)
            VS_ACTIVE:      n = VS_FRONT_PORCH;
            VS_FRONT_PORCH: n = VS_SYNC;
            VS_SYNC:        n = VS_BACK_PORCH;
            VS_BACK_PORCH:  n = VS_ACTIVE;
            default:        n = VS_ACTIVE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/v_syncer.sv
// Vertical timing generator: counts line_complete strobes and produces v_sync,
// v_active, line_index and a frame-wrap pulse with a modulo-256 frame counter.
//
// state          | meaning
// ---------------+------------------------------------------
// VS_ACTIVE      | visible lines, v_active=1
// VS_FRONT_PORCH | blank lines before sync
// VS_SYNC        | v_sync driven to SYNC_POL
// VS_BACK_PORCH  | blank lines after sync, frame wraps at end
module v_syncer
    import vga_timing_pkg::*;
#(
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = SYNC_POL_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_complete,
    output logic       v_sync,
    output logic       v_active,
    output logic [9:0] line_index,
    output logic       frame_complete,
    output logic [7:0] frame_count
);

    localparam int TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || TOTAL > 1024) begin : g_param_check
        $error("v_syncer: every vertical length must be >= 1 and the total <= 1024");
    end

    localparam logic [9:0] ACTIVE_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] FP_LAST     = 10'(V_FP - 1);
    localparam logic [9:0] SYNC_LAST   = 10'(V_SYNC - 1);
    localparam logic [9:0] BP_LAST     = 10'(V_BP - 1);

    v_state_t   state;
    v_state_t   state_nxt;
    logic [9:0] phase;
    logic [9:0] phase_last;
    logic       phase_done;
    logic       frame_wrap;

    always_comb begin
        phase_last = ACTIVE_LAST;
        case (state)
            VS_ACTIVE:      phase_last = ACTIVE_LAST;
            VS_FRONT_PORCH: phase_last = FP_LAST;
            VS_SYNC:        phase_last = SYNC_LAST;
            VS_BACK_PORCH:  phase_last = BP_LAST;
            default:        phase_last = ACTIVE_LAST;
        endcase
    end

    assign phase_done = (phase == phase_last);
    assign state_nxt  = phase_done ? next_v_state(state) : state;
    // The end of back porch is the end of the frame, so no separate TOTAL compare is needed
    assign frame_wrap = phase_done && (state == VS_BACK_PORCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= VS_ACTIVE;
            phase          <= '0;
            line_index     <= '0;
            v_active       <= 1'b1;
            v_sync         <= ~SYNC_POL;
            frame_complete <= 1'b0;
            frame_count    <= '0;
        end else begin
            frame_complete <= 1'b0;
            if (line_complete) begin
                state      <= state_nxt;
                phase      <= phase_done ? 10'd0 : phase + 10'd1;
                line_index <= frame_wrap ? 10'd0 : line_index + 10'd1;
                v_active   <= (state_nxt == VS_ACTIVE);
                v_sync     <= (state_nxt == VS_SYNC) ? SYNC_POL : ~SYNC_POL;
                if (frame_wrap) begin
                    frame_complete <= 1'b1;
                    frame_count    <= frame_count + 8'd1;
                end
            end
        end
    end

endmodule
